// File: rtl/display_shift_receiver_if.sv
// Serial display link as seen by the loopback receiver: five link lines in,
// latched frame image and commit strobes out.
interface display_shift_receiver_if #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_BITS   = 8
);
    logic                         all_nrst;
    logic                         control_reg_clk;
    logic                         all_bit_clk;
    logic                         control_data_ser;
    logic                         digit_data_ser;
    logic [SEG_BITS-1:0]          seg_latched;
    logic [NUM_DIGITS-1:0]        digit_sel_latched;
    logic [NUM_DIGITS*SEG_BITS-1:0] digit_mem_out;
    logic                         frame_valid;
    logic                         frame_err;

    modport master (
        output all_nrst, control_reg_clk, all_bit_clk, control_data_ser, digit_data_ser,
        input  seg_latched, digit_sel_latched, digit_mem_out, frame_valid, frame_err
    );

    modport slave (
        input  all_nrst, control_reg_clk, all_bit_clk, control_data_ser, digit_data_ser,
        output seg_latched, digit_sel_latched, digit_mem_out, frame_valid, frame_err
    );
endinterface

// File: rtl/display_shift_receiver.sv
// Oversampling receiver for the display shift-register link; reproduces what the
// external board latches and keeps a per-digit segment image.
//
// state | meaning
// IDLE  | link reset (synchronized all_nrst low); everything held clear
// RUN   | link active; shift on bit_clk rise, then commit on reg_clk rise
module display_shift_receiver #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_BITS   = 8,
    parameter int FRAME_BITS = 8
) (
    input  logic g_clk,
    input  logic g_rst,
    display_shift_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    // pin order: {nrst, reg_clk, bit_clk, ctl, digit}
    logic [4:0] sync1, sync2;
    logic       prev_bit, prev_reg;
    logic       nrst_s, bit_rise, reg_rise;

    logic [SEG_BITS-1:0]   seg_sr, seg_next, seg_latched;
    logic [NUM_DIGITS-1:0] ctl_sr, ctl_next, digit_sel_latched;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;
    logic [SEG_BITS-1:0]   digit_mem [NUM_DIGITS];
    logic [NUM_DIGITS*SEG_BITS-1:0] mem_flat;
    logic frame_valid, frame_err;
    logic do_clear, do_shift, do_commit;
    logic multi_sel, seen_sel, frame_bad;

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            sync1    <= '0;
            sync2    <= '0;
            prev_bit <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            sync1    <= {bus.all_nrst, bus.control_reg_clk, bus.all_bit_clk,
                         bus.control_data_ser, bus.digit_data_ser};
            sync2    <= sync1;
            prev_bit <= sync2[2];
            prev_reg <= sync2[3];
        end
    end

    assign nrst_s   = sync2[4];
    assign bit_rise = sync2[2] & ~prev_bit;
    assign reg_rise = sync2[3] & ~prev_reg;

    always_ff @(posedge g_clk) begin
        if (g_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                do_clear = 1'b1;
                if (nrst_s) state_nxt = RUN;
            end
            RUN: begin
                if (!nrst_s) begin
                    do_clear  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_shift  = bit_rise;
                    do_commit = reg_rise;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift is resolved first so a coincident commit sees the post-shift frame.
    always_comb begin
        seg_next  = seg_sr;
        ctl_next  = ctl_sr;
        cnt_next  = bit_cnt;
        multi_sel = 1'b0;
        seen_sel  = 1'b0;
        if (do_shift) begin
            seg_next = {seg_sr[SEG_BITS-2:0], sync2[0]};
            ctl_next = {ctl_sr[NUM_DIGITS-2:0], sync2[1]};
            if (bit_cnt != '1) cnt_next = bit_cnt + 1'b1;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ctl_next[k]) begin
                if (seen_sel) multi_sel = 1'b1;
                seen_sel = 1'b1;
            end
        end
        frame_bad = (cnt_next != CNT_W'(FRAME_BITS)) || multi_sel;
    end

    always_ff @(posedge g_clk) begin
        if (g_rst || do_clear) begin
            seg_sr            <= '0;
            ctl_sr            <= '0;
            bit_cnt           <= '0;
            seg_latched       <= '0;
            digit_sel_latched <= '0;
            frame_valid       <= 1'b0;
            frame_err         <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) digit_mem[k] <= '0;
        end else begin
            seg_sr      <= seg_next;
            ctl_sr      <= ctl_next;
            bit_cnt     <= do_commit ? '0 : cnt_next;
            frame_valid <= do_commit;
            frame_err   <= do_commit & frame_bad;
            if (do_commit) begin
                seg_latched       <= seg_next;
                digit_sel_latched <= ctl_next;
                // blank (all-zero) selects write nothing; errored frames never write
                if (!frame_bad) begin
                    for (int k = 0; k < NUM_DIGITS; k++)
                        if (ctl_next[k]) digit_mem[k] <= seg_next;
                end
            end
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            mem_flat[k*SEG_BITS +: SEG_BITS] = digit_mem[k];
    end

    assign bus.seg_latched       = seg_latched;
    assign bus.digit_sel_latched = digit_sel_latched;
    assign bus.digit_mem_out     = mem_flat;
    assign bus.frame_valid       = frame_valid;
    assign bus.frame_err         = frame_err;
endmodule

// File: doc/display_shift_receiver.md
Name: display_shift_receiver

Overview:
- Receive-side model of the serial display link: deserializes all_nrst / control_reg_clk / all_bit_clk / control_data_ser / digit_data_ser exactly as the external shift-register board interprets them.
- Sits on the FPGA fabric, in the g_clk domain, as a loopback monitor of the timer integration's display outputs. It supports on-chip self-check and provides a per-digit segment image for the ILA or for a secondary display.
- Oversamples all serial lines with g_clk. The link clocks are treated as data, not as clocks.

Parameters:
- NUM_DIGITS, 6, number of digits; width of the control (digit-select) shift register.
- SEG_BITS, 8, width of the digit-data shift register (7 segments + dp, bit 7 = dp).
- FRAME_BITS, 8, required all_bit_clk rising edges per frame; must be >= max(SEG_BITS, NUM_DIGITS).

Ports:
- g_clk  in  1  system clock, 100 MHz.
- g_rst  in  1  synchronous active-high reset.
- all_nrst  in  1  link reset, active low.
- control_reg_clk  in  1  link latch strobe; frame commits on its rising edge.
- all_bit_clk  in  1  link shift clock; shifts on its rising edge.
- control_data_ser  in  1  serial digit-select bit, MSB first.
- digit_data_ser  in  1  serial segment bit, MSB first.
- seg_latched  out  SEG_BITS  last latched segment word.
- digit_sel_latched  out  NUM_DIGITS  last latched digit select (active-high).
- digit_mem_out  out  NUM_DIGITS*SEG_BITS  per-digit segment image; digit k at [k*SEG_BITS +: SEG_BITS].
- frame_valid  out  1  one-cycle pulse on each commit.
- frame_err  out  1  one-cycle pulse, coincident with frame_valid, when the frame is malformed.

Behaviour:
- Input conditioning: all five link inputs pass through 2-flop synchronizers clocked by g_clk. Synchronizer flops clear to 0 on g_rst.
- Edge detection: a third register per clock line stores the previous synchronized value. A rising edge is sync=1 and prev=0.
- Latency: an input transition acts 3 g_clk cycles after it appears on the pin.
- Data sampling: data bits are sampled from the synchronized data lines in the same cycle the all_bit_clk rising edge is detected.
- Transmitter constraints: each link clock level is held >= 3 g_clk cycles; data is stable >= 3 cycles before and 1 cycle after the bit_clk rise.
- Link reset (synchronized all_nrst=0):
  - Clears both shift registers, bit_cnt, seg_latched, digit_sel_latched and digit_mem_out.
  - Edges are ignored while all_nrst is low.
  - The outputs frame_valid and frame_err stay 0.
- g_rst: the same clears as link reset, plus the synchronizers and edge registers. All outputs reset to 0.
- Shift, on an all_bit_clk rise:
  - seg_sr <= {seg_sr[SEG_BITS-2:0], digit_bit}.
  - ctl_sr <= {ctl_sr[NUM_DIGITS-2:0], ctl_bit}.
  - bit_cnt increments and saturates at 2^ceil(log2(FRAME_BITS+2))-1.
- Commit, on a control_reg_clk rise:
  - seg_latched <= seg_sr; digit_sel_latched <= ctl_sr; bit_cnt <= 0; frame_valid pulses.
- Simultaneous bit_clk and reg_clk rise in the same cycle: the shift applies first. The commit latches the post-shift values, and bit_cnt counts that bit before clearing to 0.
- Error check at commit: frame_err=1 if bit_cnt (including any simultaneous bit) != FRAME_BITS, or if popcount(ctl)>1.
- Memory write:
  - Only when the commit is error-free. digit_mem_out[k] <= seg value for the single k with ctl[k]=1.
  - ctl all-zero is legal: it is a blank frame, latched outputs update, and no memory write occurs.
- Errored frames still update seg_latched and digit_sel_latched, which mirrors the board hardware. The memory is not written.
- Commit with zero shifted bits: latches the current shift-register contents and flags frame_err (count 0 != FRAME_BITS).
- Link reset asserted mid-frame: partial bits are discarded. The first post-release frame counts from 0.
- Implementation FSM, per cycle: IDLE (nrst low) and RUN (nrst high). RUN evaluates shift, then commit, as above. IDLE→RUN on synchronized nrst=1; RUN→IDLE on nrst=0 or g_rst.

Test Plan:
1. Reset values: g_rst=1 for 2 cycles → all outputs 0, frame_valid=0. Then all_nrst=1, idle lines → no pulses for 1000 cycles.
2. Nominal frame: shift segs 8'b1011_0110 and ctl 6'b000100 (ctl sent as 8 bits: 2 leading zeros), 8 bit_clk rises of 4 cycles/level, then reg_clk rise. Response: frame_valid pulse 3 cycles after the reg_clk pin rise, seg_latched=8'hB6, digit_sel_latched=6'b000100, digit_mem_out[23:16]=8'hB6, other digits 0, frame_err=0.
3. Short frame: 7 bit clocks, then latch → frame_err=1 with frame_valid, latched outputs updated, digit_mem_out unchanged.
4. Multi-select: 8 bits with ctl=6'b100001 → frame_err=1, memory unchanged. Follow with a good frame to digit 0 with 8'h3F → mem[7:0]=8'h3F, no error.
5. Coincident edges: 7th→8th bit_clk rise in the same g_clk cycle as the reg_clk rise → commit includes the 8th bit, frame_err=0, bit_cnt=0 afterwards.
6. Mid-frame link reset: 4 bits, all_nrst low 10 cycles, released, then a full 8-bit frame to digit 5 with 8'h06 → only mem[47:40]=8'h06. Earlier memory contents are cleared to 0 by the link reset.
